// File: rtl/mem_hazard_ctrl.sv
// Purpose : pipeline sequencing for the 8-bit five-stage core (memory freeze, load-use bubble, branch flush).
// Latency : memory op costs 1 IDLE stall cycle + ack wait; load-use 1 bubble; taken branch 2 flushed slots.
// Backpr.  : dmReq/dmAck handshake freezes every stage until completion; no ack within TIMEOUT cycles -> sticky ERROR.
//
// Ports:
//   clk, rst                      clock (rising edge) and asynchronous active-low reset
//   exmemMemRead, exmemMemWrite   EX/MEM holds a load / store
//   dmAck                         data memory completion, only looked at while in ACCESS
//   idexMemRead, idexDest         ID/EX load flag and destination register
//   ifidSrc1, ifidSrc2,
//   ifidUsesSrc2                  IF/ID source registers and src2-used flag
//   branchTaken                   branch resolved taken this cycle
//   dmReq                         memory request, high in ACCESS only (registered)
//   pcWrite .. memwbWrite         write enables of PC and the four pipeline registers
//   ifidFlush, idexFlush          load a NOP into IF/ID / ID/EX on the next edge
//   busy                          sequencer is not IDLE (registered)
//   memErr                        sticky memory timeout (registered)

module mem_hazard_ctrl #(
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exmemMemRead,
    input  logic              exmemMemWrite,
    input  logic              dmAck,
    input  logic              idexMemRead,
    input  logic [ADDR_W-1:0] idexDest,
    input  logic [ADDR_W-1:0] ifidSrc1,
    input  logic [ADDR_W-1:0] ifidSrc2,
    input  logic              ifidUsesSrc2,
    input  logic              branchTaken,
    output logic              dmReq,
    output logic              pcWrite,
    output logic              ifidWrite,
    output logic              idexWrite,
    output logic              exmemWrite,
    output logic              memwbWrite,
    output logic              ifidFlush,
    output logic              idexFlush,
    output logic              busy,
    output logic              memErr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERROR  = 2'd3
    } ctrlStateT;

    // Last ACCESS cycle index before the timeout fires.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    ctrlStateT        state;
    logic [CNT_W-1:0] cnt;

    logic memOp;
    logic memStall;
    logic luHazard;
    logic srcMatch;

    assign memOp = exmemMemRead | exmemMemWrite;

    // ------------------------------------------------------------------
    // Memory access sequencer. dmReq, busy and memErr are updated together
    // with the state so they are clean flop outputs; the async reset clears
    // them immediately, so dmReq drops without waiting for a clock.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dmReq  <= 1'b0;
            busy   <= 1'b0;
            memErr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // EX/MEM is re-examined every IDLE cycle, so a memory op
                    // arriving right after DONE gets its own access.
                    if (memOp) begin
                        state <= ACCESS;
                        cnt   <= '0;
                        dmReq <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                ACCESS: begin
                    // An ack in the final count cycle still completes normally.
                    if (dmAck) begin
                        state <= DONE;
                        dmReq <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= ERROR;
                        dmReq  <= 1'b0;
                        memErr <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    // Pipeline advances this cycle; MEM/WB captures the result.
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                ERROR: begin
                    // Terminal until reset: everything held.
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    dmReq  <= 1'b0;
                    busy   <= 1'b0;
                    memErr <= 1'b0;
                end
            endcase
        end
    end

    // The IDLE term stalls the cycle the op first shows up in EX/MEM, before
    // the request has even been issued.
    assign memStall = ((state == IDLE) && memOp) || (state == ACCESS) || (state == ERROR);

    // Register 0 reads as constant zero, so a load targeting it never hazards.
    assign srcMatch = (idexDest == ifidSrc1) || (ifidUsesSrc2 && (idexDest == ifidSrc2));
    assign luHazard = idexMemRead && (idexDest != '0) && srcMatch;

    // ------------------------------------------------------------------
    // Stage enables and flushes, highest priority first. A memory stall
    // swallows any concurrent branch or hazard; those inputs are simply
    // re-evaluated once the freeze lifts.
    // ------------------------------------------------------------------
    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        idexWrite  = 1'b1;
        exmemWrite = 1'b1;
        memwbWrite = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;

        if (memStall) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbWrite = 1'b0;
        end else if (branchTaken) begin
            // Both younger instructions are on the wrong path.
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (luHazard) begin
            // Hold PC and IF/ID, push a bubble into ID/EX, let older stages drain.
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
        end
    end

endmodule
